// File: rtl/lsu.sv
// lsu: initiator side of the word-addressed data-memory port.
// Byte/half loads with extension; sub-word stores done as read-modify-write.
module lsu (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_write,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RD_DATA,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [31:0] r_mem_addr;
   logic        r_mem_write;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;

   logic        w_misal;
   logic        w_acc_err;
   logic        w_acc_ld;
   logic        w_acc_wst;
   logic        w_acc_sst;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   assign w_misal = (i_req_size == 2'b11)
                  | ((i_req_size == 2'b01) & i_req_addr[0])
                  | ((i_req_size == 2'b10) & (i_req_addr[1:0] != 2'b00));

   assign w_acc_err = w_misal;
   assign w_acc_ld  = ~w_misal & ~i_req_we;
   assign w_acc_wst = ~w_misal & i_req_we & (i_req_size == 2'b10);
   assign w_acc_sst = ~w_misal & i_req_we & (i_req_size != 2'b10);

   // Lane select/extension for loads and lane merge for sub-word stores
   always_comb begin
      w_byte  = i_mem_rdata[{r_off, 3'b000} +: 8];
      w_half  = i_mem_rdata[{r_off[1], 4'b0000} +: 16];
      w_load  = i_mem_rdata;
      w_merge = i_mem_rdata;
      case (r_size)
         2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
         default: w_load = i_mem_rdata;
      endcase
      if (r_size == 2'b00) begin
         w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end else begin
         w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
   end

   // Request sequencing FSM with registered memory and response outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_size      <= 2'b00;
         r_uns       <= 1'b0;
         r_off       <= 2'b00;
         r_wdata     <= 32'h0;
         r_mem_addr  <= 32'h0;
         r_mem_write <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'h0;
      end else begin
         r_mem_write <= 1'b0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_size     <= i_req_size;
                  r_uns      <= i_req_unsigned;
                  r_off      <= i_req_addr[1:0];
                  r_wdata    <= i_req_wdata;
                  r_mem_addr <= {2'b00, i_req_addr[31:2]};
                  unique case (1'b1)
                     w_acc_err: begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                     end
                     w_acc_ld: begin
                        r_state <= S_RD;
                     end
                     w_acc_wst: begin
                        r_state     <= S_WR;
                        r_mem_write <= 1'b1;
                     end
                     w_acc_sst: begin
                        r_state <= S_RMW_RD;
                     end
                     default: begin
                        r_state <= S_IDLE;
                     end
                  endcase
               end
            end
            S_RD: begin
               r_state <= S_RD_DATA;
            end
            S_RD_DATA: begin
               r_rsp_rdata <= w_load;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_WR: begin
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RMW_RD: begin
               r_mem_write <= 1'b1;
               r_state     <= S_RMW_WR;
            end
            S_RMW_WR: begin
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               r_rsp_rdata <= 32'h0;
               r_rsp_err   <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_write = r_mem_write;
   assign o_mem_wdata = (r_state == S_RMW_WR) ? w_merge :
                        (r_state == S_WR)     ? r_wdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: load/store unit bench with a word-array memory and a
// byte-lane reference model of the expected memory image.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem     [0:63];
   logic [31:0] exp_mem [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_idx;
   logic [31:0] bd_dat;

   always #5 clk = ~clk;

   lsu dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_unsigned (req_uns),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_rdata    (rsp_rdata),
      .o_rsp_err      (rsp_err),
      .o_mem_addr     (mem_addr),
      .o_mem_write    (mem_write),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (mem_rdata)
   );

   // Single-cycle-read word memory with a backdoor preload port
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_dat;
      else if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[5:0]];
   end

   function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                          input logic u);
      logic [31:0] v;
      int sh;
      sh = int'(a[1:0]) * 8;
      v = exp_mem[a[7:2]] >> sh;
      if (sz == 2'd0) begin
         v = v & 32'hFF;
         if (!u && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] mask;
      int sh;
      sh = int'(a[1:0]) * 8;
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      exp_mem[a[7:2]] = (exp_mem[a[7:2]] & ~(mask << sh)) | ((d & mask) << sh);
   endtask

   task automatic bd_write(input int idx, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1;
      bd_idx = idx[5:0];
      bd_dat = d;
      exp_mem[idx] = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // One transaction from IDLE; reports what the port did, cycle by cycle
   task automatic xact(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwr, output logic [31:0] wd, output logic [31:0] wa,
                       output logic rdy);
      lat = -1; rd = 32'h0; er = 1'b0; nwr = 0; wd = 32'h0; wa = 32'h0; rdy = 1'b0;
      @(negedge clk);
      req_we = we; req_size = sz; req_uns = u; req_addr = a; req_wdata = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (lat >= 0) begin
            rdy = req_ready & ~rsp_valid;
            break;
         end
         if (mem_write) begin nwr++; wd = mem_wdata; wa = mem_addr; end
         if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready got %b want 1", req_ready);
      end
      n_cmp++;
      if ({rsp_valid, rsp_err, mem_write} !== 3'b000) begin
         n_bad++; $display("FAIL reset_ctl got %b want 000", {rsp_valid, rsp_err, mem_write});
      end
      n_cmp++;
      if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         n_bad++; $display("FAIL reset_data got %h %h %h want 0", rsp_rdata, mem_addr, mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_word;
      int lat, nwr; logic [31:0] rd, wd, wa; logic er, rdy;
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwr, wd, wa, rdy);
      m_store(32'h10, 2'd2, 32'hDEADBEEF);
      n_cmp++;
      if (lat !== 2 || nwr !== 1 || wa !== 32'd4 || wd !== 32'hDEADBEEF || er !== 1'b0 || !rdy) begin
         n_bad++;
         $display("FAIL sw_word got lat=%0d nwr=%0d wa=%h wd=%h err=%b rdy=%b want 2 1 4 deadbeef 0 1",
                  lat, nwr, wa, wd, er, rdy);
      end
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wd, wa, rdy);
      n_cmp++;
      if (lat !== 3 || rd !== 32'hDEADBEEF || nwr !== 0 || er !== 1'b0 || !rdy) begin
         n_bad++;
         $display("FAIL lw_word got lat=%0d rd=%h nwr=%0d err=%b rdy=%b want 3 deadbeef 0 0 1",
                  lat, rd, nwr, er, rdy);
      end
   endtask

   task automatic test_byte_loads;
      logic [31:0] ad [6];
      logic [1:0]  sz [6];
      logic        us [6];
      logic [31:0] ex [6];
      int lat, nwr; logic [31:0] rd, wd, wa; logic er, rdy;
      ad = '{32'h23, 32'h23, 32'h21, 32'h22, 32'h20, 32'h22};
      sz = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
      us = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ex = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
             32'hFFFF80FF, 32'h00007F01, 32'hFFFFFFFF};
      bd_write(8, 32'h80FF7F01);
      for (int i = 0; i < 6; i++) begin
         xact(1'b0, sz[i], us[i], ad[i], 32'h0, lat, rd, er, nwr, wd, wa, rdy);
         n_cmp++;
         if (lat !== 3 || rd !== ex[i] || er !== 1'b0 || nwr !== 0) begin
            n_bad++;
            $display("FAIL subload_%0d got lat=%0d rd=%h err=%b nwr=%0d want 3 %h 0 0",
                     i, lat, rd, er, nwr, ex[i]);
         end
      end
   endtask

   task automatic test_rmw;
      int lat, nwr; logic [31:0] rd, wd, wa; logic er, rdy;
      bd_write(12, 32'h11223344);
      xact(1'b1, 2'd0, 1'b0, 32'h31, 32'h5A5A_5AAB, lat, rd, er, nwr, wd, wa, rdy);
      m_store(32'h31, 2'd0, 32'h5A5A_5AAB);
      n_cmp++;
      if (lat !== 3 || nwr !== 1 || wd !== 32'h1122AB44 || wa !== 32'd12 || !rdy) begin
         n_bad++;
         $display("FAIL sb_rmw got lat=%0d nwr=%0d wd=%h wa=%h rdy=%b want 3 1 1122ab44 c 1",
                  lat, nwr, wd, wa, rdy);
      end
      xact(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, rd, er, nwr, wd, wa, rdy);
      n_cmp++;
      if (rd !== 32'h1122AB44) begin
         n_bad++; $display("FAIL sb_readback got %h want 1122ab44", rd);
      end
      xact(1'b1, 2'd1, 1'b0, 32'h32, 32'h1234_CAFE, lat, rd, er, nwr, wd, wa, rdy);
      m_store(32'h32, 2'd1, 32'h1234_CAFE);
      n_cmp++;
      if (lat !== 3 || nwr !== 1 || wd !== 32'hCAFEAB44) begin
         n_bad++;
         $display("FAIL sh_rmw got lat=%0d nwr=%0d wd=%h want 3 1 cafeab44", lat, nwr, wd);
      end
      xact(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, rd, er, nwr, wd, wa, rdy);
      n_cmp++;
      if (rd !== 32'hCAFEAB44) begin
         n_bad++; $display("FAIL sh_readback got %h want cafeab44", rd);
      end
   endtask

   task automatic test_misaligned;
      logic        we [3];
      logic [1:0]  sz [3];
      logic [31:0] ad [3];
      int lat, nwr; logic [31:0] rd, wd, wa; logic er, rdy;
      we = '{1'b0, 1'b1, 1'b1};
      sz = '{2'd2, 2'd1, 2'd3};
      ad = '{32'h05, 32'h07, 32'h04};
      for (int i = 0; i < 3; i++) begin
         xact(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, lat, rd, er, nwr, wd, wa, rdy);
         n_cmp++;
         if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0 || !rdy) begin
            n_bad++;
            $display("FAIL misal_%0d got lat=%0d err=%b rd=%h nwr=%0d rdy=%b want 1 1 0 0 1",
                     i, lat, er, rd, nwr, rdy);
         end
      end
      n_cmp++;
      if (mem[1] !== exp_mem[1]) begin
         n_bad++; $display("FAIL misal_mem got %h want %h", mem[1], exp_mem[1]);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ba [3];
      logic [31:0] ex [3];
      int rc[$];
      int ac[$];
      logic [31:0] rq[$];
      int n = 0;
      int waits = 0;
      logic acc;
      ba = '{32'hC8, 32'hCC, 32'hD0};
      for (int i = 0; i < 3; i++) ex[i] = m_load(ba[i], 2'd2, 1'b0);
      @(posedge clk);
      #1;
      req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = ba[0];
      req_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (rsp_valid) begin rc.push_back(c); rq.push_back(rsp_rdata); end
         acc = req_ready & req_valid;
         if (req_valid && !req_ready) waits++;
         if (acc) ac.push_back(c);
         @(posedge clk);
         #1;
         if (acc) begin
            n++;
            if (n < 3) req_addr = ba[n];
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      n_cmp++;
      if (rc.size() !== 3 || ac.size() !== 3) begin
         n_bad++; $display("FAIL b2b_count got rsp=%0d acc=%0d want 3 3", rc.size(), ac.size());
      end else begin
         n_cmp++;
         if (rc[1] - rc[0] !== 4 || rc[2] - rc[1] !== 4 || rc[0] - ac[0] !== 3) begin
            n_bad++;
            $display("FAIL b2b_spacing got rsp=%0d,%0d,%0d acc0=%0d want 4 apart, 3 after",
                     rc[0], rc[1], rc[2], ac[0]);
         end
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rq[i] !== ex[i]) begin
               n_bad++; $display("FAIL b2b_data_%0d got %h want %h", i, rq[i], ex[i]);
            end
         end
      end
      n_cmp++;
      if (waits < 6) begin
         n_bad++; $display("FAIL b2b_held got %0d stalled cycles want >=6", waits);
      end
   endtask

   task automatic test_reset_rmw;
      int bad = 0;
      bd_write(40, 32'h55667788);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0; req_addr = 32'hA1;
      req_wdata = 32'h99; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_async got wr=%b rv=%b rdy=%b want 0 0 1", mem_write, rsp_valid, req_ready);
      end
      repeat (3) begin
         @(negedge clk);
         if (mem_write || rsp_valid) bad++;
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mem_write || rsp_valid) bad++;
      end
      n_cmp++;
      if (bad !== 0 || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_rmw_quiet got bad=%0d rdy=%b want 0 1", bad, req_ready);
      end
      n_cmp++;
      if (mem[40] !== 32'h55667788) begin
         n_bad++; $display("FAIL rst_rmw_mem got %h want 55667788", mem[40]);
      end
   endtask

   task automatic test_random;
      int lat, nwr, e_lat, e_nwr, nm;
      logic [31:0] rd, wd, wa, a, d, e_rd, e_wd, e_wa;
      logic er, rdy, we, u, bad;
      logic [1:0] sz;
      for (int i = 0; i < 80; i++) begin
         sz = 2'($urandom_range(0, 3));
         we = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         d  = $urandom;
         a  = 32'($urandom_range(0, 63)) * 4;
         if ($urandom_range(0, 9) < 7) begin
            if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
         end else begin
            a = a + 32'($urandom_range(0, 3));
         end
         bad   = m_misal(sz, a);
         e_lat = bad ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 3));
         e_rd  = (bad || we) ? 32'h0 : m_load(a, sz, u);
         e_nwr = (bad || !we) ? 0 : 1;
         if (e_nwr == 1) m_store(a, sz, d);
         e_wd  = (e_nwr == 1) ? exp_mem[a[7:2]] : 32'h0;
         e_wa  = (e_nwr == 1) ? (a >> 2) : 32'h0;
         xact(we, sz, u, a, d, lat, rd, er, nwr, wd, wa, rdy);
         n_cmp++;
         if (lat !== e_lat || er !== bad || rd !== e_rd || nwr !== e_nwr ||
             wd !== e_wd || wa !== e_wa || !rdy) begin
            n_bad++;
            $display("FAIL rand_%0d we=%b sz=%0d a=%h got lat=%0d err=%b rd=%h nwr=%0d wd=%h wa=%h rdy=%b want %0d %b %h %0d %h %h 1",
                     i, we, sz, a, lat, er, rd, nwr, wd, wa, rdy, e_lat, bad, e_rd, e_nwr, e_wd, e_wa);
         end
      end
      nm = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) nm++;
      n_cmp++;
      if (nm !== 0) begin
         n_bad++; $display("FAIL mem_image got %0d differing words want 0", nm);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      test_reset;
      for (int i = 0; i < 64; i++) bd_write(i, $urandom);
      test_word;
      test_byte_loads;
      test_rmw;
      test_misaligned;
      test_back_to_back;
      test_reset_rmw;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
